// File: rtl/ddr3_app_pkg.sv
// Shared command codes, FSM encoding and mask helper for the DDR3 app-interface model.
package ddr3_app_pkg;

    localparam logic [2:0] WT_CMD = 3'd0;
    localparam logic [2:0] RD_CMD = 3'd1;

    // Widest supported data bus is 512 bits (64 mask bytes).
    localparam int MAX_MASK_BYTES = 64;

    typedef enum logic [2:0] {
        ST_CALIB   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_READ    = 3'd4
    } ddr3_state_e;

    // Expands a per-byte enable into a per-bit enable; callers truncate to their width.
    function automatic logic [MAX_MASK_BYTES*8-1:0] expand_mask(
        input logic [MAX_MASK_BYTES-1:0] byte_en
    );
        logic [MAX_MASK_BYTES*8-1:0] bit_en;
        bit_en = '0;
        for (int j = 0; j < MAX_MASK_BYTES; j++) begin
            bit_en[j*8 +: 8] = {8{byte_en[j]}};
        end
        return bit_en;
    endfunction

endpackage

// File: rtl/ddr3_model_mem.sv
// Byte-enabled DEPTH x DATA_W storage array with synchronous write and registered read.
module ddr3_model_mem #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_bit_en,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The array itself is never reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= (mem[wr_addr] & ~wr_bit_en) | (wr_data & wr_bit_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ddr3_app_model.sv
// Behavioural DDR3 app-interface model: calibration delay, burst write/read, byte masks.
module ddr3_app_model
    import ddr3_app_pkg::*;
#(
    parameter int DATA_W       = 128,
    parameter int ADDR_W       = 28,
    parameter int DEPTH        = 1024,
    parameter int CALIB_CYCLES = 256,
    parameter int RD_LAT       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          app_burst_number,
    output logic                cmd_ready,
    input  logic [2:0]          cmd,
    input  logic                cmd_en,
    input  logic [ADDR_W-1:0]   addr,
    output logic                wr_data_rdy,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_data_en,
    input  logic                wr_data_end,
    input  logic [DATA_W/8-1:0] wr_data_mask,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_data_valid,
    output logic                rd_data_end,
    output logic                init_calib_complete
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam int LW = $clog2(RD_LAT + 1);

    localparam logic [2:0] S_CALIB   = ST_CALIB;
    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_WRITE   = ST_WRITE;
    localparam logic [2:0] S_RD_WAIT = ST_RD_WAIT;
    localparam logic [2:0] S_READ    = ST_READ;

    logic [2:0]          state;
    logic [CW-1:0]       calib_cnt;
    logic [LW-1:0]       lat_cnt;
    logic [6:0]          beat_len;
    logic [6:0]          beat_cnt;
    logic [AW-1:0]       base;
    logic                wr_beat;
    logic                wr_last;
    logic                rd_issue;
    logic [AW-1:0]       beat_addr;
    logic [DATA_W/8-1:0] byte_wr_en;
    logic [DATA_W-1:0]   bit_wr_en;
    logic                unused_addr_hi;

    assign cmd_ready      = (state == S_IDLE);
    assign wr_data_rdy    = (state == S_WRITE);
    assign wr_beat        = rst_n && (state == S_WRITE) && wr_data_en;
    assign wr_last        = wr_data_end || (beat_cnt == beat_len - 7'd1);
    assign rd_issue       = rst_n && (state == S_READ) && (beat_cnt != beat_len);
    assign beat_addr      = base + AW'(beat_cnt);
    assign byte_wr_en     = ~wr_data_mask;
    assign bit_wr_en      = DATA_W'(expand_mask(MAX_MASK_BYTES'(byte_wr_en)));
    assign unused_addr_hi = ^addr[ADDR_W-1:AW];

    // The read leg spends one READ cycle past the last issue so cmd_ready
    // reappears only after the final beat has been presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= S_CALIB;
            calib_cnt           <= '0;
            lat_cnt             <= '0;
            beat_len            <= 7'd1;
            beat_cnt            <= '0;
            base                <= '0;
            init_calib_complete <= 1'b0;
            rd_data_valid       <= 1'b0;
            rd_data_end         <= 1'b0;
        end else begin
            rd_data_valid <= rd_issue;
            rd_data_end   <= rd_issue && (beat_cnt == beat_len - 7'd1);
            case (state)
                S_CALIB: begin
                    if (calib_cnt == CW'(CALIB_CYCLES - 1)) begin
                        state               <= S_IDLE;
                        init_calib_complete <= 1'b1;
                    end else begin
                        calib_cnt <= calib_cnt + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (cmd_en) begin
                        beat_len <= {1'b0, app_burst_number} + 7'd1;
                        base     <= addr[AW-1:0];
                        beat_cnt <= '0;
                        lat_cnt  <= '0;
                        if (cmd == WT_CMD) begin
                            state <= S_WRITE;
                        end else if (cmd == RD_CMD) begin
                            state <= (RD_LAT == 2) ? S_READ : S_RD_WAIT;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_data_en) begin
                        beat_cnt <= beat_cnt + 7'd1;
                        if (wr_last) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (lat_cnt == LW'(RD_LAT - 3)) begin
                        state <= S_READ;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                S_READ: begin
                    if (beat_cnt == beat_len) begin
                        state <= S_IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + 7'd1;
                    end
                end
                default: state <= S_CALIB;
            endcase
        end
    end

    ddr3_model_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_beat),
        .wr_addr   (beat_addr),
        .wr_data   (wr_data),
        .wr_bit_en (bit_wr_en),
        .rd_en     (rd_issue),
        .rd_addr   (beat_addr),
        .rd_data   (rd_data)
    );

endmodule

// File: doc/ddr3_app_model.md
# ddr3_app_model

Parametrised behavioural model of the DDR3 controller user (app) interface, replacing the fixed 128×128-bit stub in simulation and in FPGA bring-up builds. It takes the same command, write and read channels as the vendor controller and adds several behaviours:

- real bursts sized by `app_burst_number`;
- proper `cmd_ready` back-pressure;
- DDR3-style byte masking;
- configurable calibration delay and read latency.

It sits between the SoC memory bridge and the (absent) PHY. It is single-clock and drives no DDR pins.

## Interface
Parameters:
- `DATA_W`, 128, app data width; multiple of 8.
- `ADDR_W`, 28, app address width.
- `DEPTH`, 1024, words of `DATA_W` in the model array; power of two.
- `CALIB_CYCLES`, 256, cycles from reset release to `init_calib_complete`; ≥1.
- `RD_LAT`, 4, cycles from read-command accept to first read beat; ≥2.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low. This is already decided.
- `app_burst_number` in 6: beats per command minus 1; sampled on command accept.
- `cmd_ready` out 1: command channel ready.
- `cmd` in 3: command code; 0 = write, 1 = read.
- `cmd_en` in 1: command valid.
- `addr` in `ADDR_W`: burst base word address.
- `wr_data_rdy` out 1: write-beat ready.
- `wr_data` in `DATA_W`: write beat.
- `wr_data_en` in 1: write beat valid.
- `wr_data_end` in 1: last write beat marker.
- `wr_data_mask` in `DATA_W/8`: 1 = byte NOT written.
- `rd_data` out `DATA_W`: read beat.
- `rd_data_valid` out 1: read beat valid.
- `rd_data_end` out 1: last read beat.
- `init_calib_complete` out 1: model ready.

## Operation
- FSM states are CALIB, IDLE, WRITE, RD_WAIT, READ. Reset enters CALIB.
- **CALIB**
  - A counter runs from 0 to `CALIB_CYCLES-1`. Then the FSM moves to IDLE and `init_calib_complete` is set; it stays set until the next reset.
- **IDLE**
  - `cmd_ready` = 1; it is 0 in every other state.
  - A command is accepted when `cmd_en && cmd_ready`. On accept, the block latches:
    - `N = app_burst_number + 1` (range 1..64);
    - `base = addr[$clog2(DEPTH)-1:0]`.
  - Write goes to WRITE. Read goes to RD_WAIT.
  - Any other code is accepted and dropped; the FSM stays in IDLE.
- **WRITE**
  - `wr_data_rdy` = 1.
  - Each cycle with `wr_data_en` writes beat k to word `(base+k) mod DEPTH`. Byte j is written only if `wr_data_mask[j]` = 0; masked bytes keep their old contents.
  - The burst ends on whichever comes first: beat N-1 accepted, or a beat with `wr_data_end`. The FSM then returns to IDLE.
  - `wr_data_end` asserted without `wr_data_en` is ignored.
- **RD_WAIT / READ**
  - After the latency count, the block streams N beats on consecutive cycles. Beat k = word `(base+k) mod DEPTH`.
  - `rd_data_end` is asserted with beat N-1. The FSM then returns to IDLE.
- Only one command is outstanding at a time, so read-after-write returns the written data.
- Address arithmetic is modulo `DEPTH`. Base addresses above `DEPTH` alias.

## Timing
- **Reset values:** `cmd_ready`, `wr_data_rdy`, `rd_data_valid`, `rd_data_end`, `init_calib_complete` = 0; `rd_data` = 0.
- **Calibration:** with `rst_n` released at edge R, `init_calib_complete` and `cmd_ready` rise at edge R+`CALIB_CYCLES`.
- **Write accept:** for a command accepted at edge T, `wr_data_rdy` is 1 from T+1. Beats may stall (`wr_data_en` low) indefinitely.
- **Write completion:** after the final beat at edge E, `wr_data_rdy` = 0 and `cmd_ready` = 1 from E+1. A new command is not accepted on the final write beat's edge.
- **Read accept:** for a command accepted at edge T:
  - `rd_data_valid` = 1 on cycles T+`RD_LAT` through T+`RD_LAT`+N-1;
  - `rd_data_end` = 1 on the last of those cycles;
  - `cmd_ready` = 1 on the cycle after the last beat.
- **`rd_data` when idle:** holds the last beat when `rd_data_valid` = 0.
- **Reset mid-burst:** reset during any state aborts the burst immediately and returns to CALIB with all outputs at reset values. Calibration repeats. Array contents are retained (no array reset).

## Structure
- Package `ddr3_app_pkg` holds:
  - `WT_CMD` = 3'd0 and `RD_CMD` = 3'd1;
  - the FSM state enum;
  - the mask-expansion function (byte mask to bit mask).
- One sub-module, `ddr3_model_mem`: a synchronous-write, byte-enabled `DEPTH`×`DATA_W` array with registered read. Its one-cycle read latency is counted inside `RD_LAT`.
- The top level holds the FSM, calibration counter, beat counter and latency counter.

## Test plan
- **Calibration:** release reset with `CALIB_CYCLES` = 256 -> `init_calib_complete` and `cmd_ready` rise exactly 256 cycles later. A command issued before that is not accepted.
- **Write then read burst:** write burst N=4 at addr 0x10, data 0xA0..0xA3, mask 0; then read N=4 at 0x10 -> beats 0xA0..0xA3 appear at T+4..T+7, with `rd_data_end` at T+7.
- **Byte masking:** word 0x20 = all 0xFF; write 0 with mask 16'h00F0 -> read returns bytes 4–7 = 0xFF and all other bytes 0x00.
- **Wrap-around:** with `DEPTH` = 1024, write N=3 at addr 1023 -> data lands at words 1023, 0, 1. A read back at 1023 returns the same data in order.
- **Early end and stalls:** write N=8 with `wr_data_end` on beat 2, and `wr_data_en` gaps between beats -> only 3 words are written and `cmd_ready` returns the next cycle.
- **Reset mid-read:** assert `rst_n` low during beat 1 of an N=8 read -> `rd_data_valid` is 0 the next cycle, calibration repeats, and earlier data is still readable afterwards.
